// File: rtl/sys_exec_ctrl_if.sv
// ---------------------------------------------------------------------------
// sys_exec_ctrl_if
// Groups the run-control requests, breakpoint/datapath status and the
// controller outputs that pass between the execution controller and the
// outside world.
//
// Requests / status (driven by master, read by slave):
//   SYS_run        1   level free-run request
//   SYS_step       1   level single-step request (edge detected in slave)
//   SYS_load       1   PC load request
//   SYS_pc_load    8   PC load value
//   bp_en          1   breakpoint enable
//   bp_addr        32  breakpoint PC
//   pc_addr        32  current datapath PC
//   exception_sig  2   datapath fault flags, nonzero = fault
// Controller outputs (driven by slave, read by master):
//   dp_enable      1   datapath advance enable
//   pc_load_en     1   one-cycle PC load strobe
//   pc_load_val    8   captured PC load value
//   state          2   IDLE=00 RUN=01 STEP=10 HALT=11
//   halt_cause     2   00 none, 01 exception, 10 breakpoint
//   cycle_count    32  number of dp_enable cycles
// ---------------------------------------------------------------------------
interface sys_exec_ctrl_if;
    logic        SYS_run;
    logic        SYS_step;
    logic        SYS_load;
    logic [7:0]  SYS_pc_load;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc_addr;
    logic [1:0]  exception_sig;

    logic        dp_enable;
    logic        pc_load_en;
    logic [7:0]  pc_load_val;
    logic [1:0]  state;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_count;

    // Master is the host/datapath side issuing requests.
    modport master (
        output SYS_run, SYS_step, SYS_load, SYS_pc_load,
        output bp_en, bp_addr, pc_addr, exception_sig,
        input  dp_enable, pc_load_en, pc_load_val, state, halt_cause, cycle_count
    );

    // Slave is the execution controller itself.
    modport slave (
        input  SYS_run, SYS_step, SYS_load, SYS_pc_load,
        input  bp_en, bp_addr, pc_addr, exception_sig,
        output dp_enable, pc_load_en, pc_load_val, state, halt_cause, cycle_count
    );
endinterface

// File: rtl/sys_exec_ctrl.sv
// ---------------------------------------------------------------------------
// sys_exec_ctrl
// Run/step/halt controller for a simple datapath. Decides each cycle whether
// the datapath may advance one instruction, stops on breakpoints and
// exceptions, handles PC loads while idle and counts executed cycles.
//
// Ports:
//   SYS_clk    system clock, all state updates on the rising edge
//   SYS_reset  synchronous active-high reset
//   bus        sys_exec_ctrl_if.slave, carries requests, datapath status
//              and all controller outputs
// ---------------------------------------------------------------------------
module sys_exec_ctrl (
    input  logic           SYS_clk,
    input  logic           SYS_reset,
    sys_exec_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        HALT = 2'b11
    } state_t;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_EXCEPTION = 2'b01;
    localparam logic [1:0] CAUSE_BREAK     = 2'b10;

    state_t      r_state;
    state_t      w_nextState;
    logic [1:0]  r_haltCause;
    logic [1:0]  w_nextHaltCause;
    logic [31:0] r_cycleCount;
    logic        r_pcLoadEn;
    logic [7:0]  r_pcLoadVal;
    logic        r_stepQ;
    logic        r_entry;

    logic        w_stepPulse;
    logic        w_bpHit;
    logic        w_fault;
    logic        w_loadAccept;
    logic        w_dpEnable;

    // r_entry masks the breakpoint compare on the first RUN cycle after
    // leaving IDLE, so resuming while parked on the breakpoint PC executes
    // that instruction instead of halting again immediately.
    assign w_stepPulse  = bus.SYS_step & ~r_stepQ;
    assign w_bpHit      = bus.bp_en & (bus.pc_addr == bus.bp_addr) & ~r_entry;
    assign w_fault      = |bus.exception_sig;
    assign w_loadAccept = (r_state == IDLE) & bus.SYS_load;

    // Next-state, halt-cause and datapath-enable decode. A load request in
    // IDLE takes priority over run/step and keeps the controller idle. An
    // exception only counts on a cycle where the datapath actually advanced;
    // a breakpoint hit suppresses advance, so the two never coincide in RUN.
    always_comb begin
        w_nextState     = r_state;
        w_nextHaltCause = r_haltCause;
        w_dpEnable      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!bus.SYS_load) begin
                    if (w_stepPulse) begin
                        w_nextState = STEP;
                    end else if (bus.SYS_run) begin
                        w_nextState = RUN;
                    end
                end
            end
            STEP: begin
                w_dpEnable = 1'b1;
                if (w_fault) begin
                    w_nextState     = HALT;
                    w_nextHaltCause = CAUSE_EXCEPTION;
                end else begin
                    w_nextState = IDLE;
                end
            end
            RUN: begin
                w_dpEnable = bus.SYS_run & ~w_bpHit;
                if (w_dpEnable && w_fault) begin
                    w_nextState     = HALT;
                    w_nextHaltCause = CAUSE_EXCEPTION;
                end else if (w_bpHit) begin
                    w_nextState     = HALT;
                    w_nextHaltCause = CAUSE_BREAK;
                end else if (!bus.SYS_run) begin
                    w_nextState = IDLE;
                end
            end
            HALT: begin
                if (!bus.SYS_run) begin
                    w_nextState     = IDLE;
                    w_nextHaltCause = CAUSE_NONE;
                end
            end
        endcase
        if (SYS_reset) begin
            w_dpEnable = 1'b0;
        end
    end

    // Control state: FSM state, halt cause, step edge history and the
    // first-RUN-cycle marker used to mask the breakpoint on resume.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            r_state     <= IDLE;
            r_haltCause <= CAUSE_NONE;
            r_stepQ     <= 1'b0;
            r_entry     <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_haltCause <= w_nextHaltCause;
            r_stepQ     <= bus.SYS_step;
            r_entry     <= (r_state == IDLE) && (w_nextState == RUN);
        end
    end

    // PC load strobe/value and the executed-cycle counter. An accepted load
    // restarts the count; otherwise every advancing cycle bumps it, wrapping
    // naturally at 32 bits.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            r_pcLoadEn   <= 1'b0;
            r_pcLoadVal  <= 8'h00;
            r_cycleCount <= 32'h0000_0000;
        end else begin
            r_pcLoadEn <= w_loadAccept;
            if (w_loadAccept) begin
                r_pcLoadVal  <= bus.SYS_pc_load;
                r_cycleCount <= 32'h0000_0000;
            end else if (w_dpEnable) begin
                r_cycleCount <= r_cycleCount + 32'd1;
            end
        end
    end

    assign bus.dp_enable   = w_dpEnable;
    assign bus.pc_load_en  = r_pcLoadEn;
    assign bus.pc_load_val = r_pcLoadVal;
    assign bus.state       = r_state;
    assign bus.halt_cause  = r_haltCause;
    assign bus.cycle_count = r_cycleCount;

endmodule

// File: tb/tb_sys_exec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sys_exec_ctrl
// Cycle-by-cycle scoreboard bench for sys_exec_ctrl. Each scenario task
// builds a table of per-cycle stimulus and the hand-derived controller
// outputs expected in that cycle; expectations are queued when a cycle's
// stimulus is driven and popped when that cycle's outputs are sampled.
// ---------------------------------------------------------------------------
module tb_sys_exec_ctrl;

    typedef struct packed {
        logic        rst;
        logic        run;
        logic        step;
        logic        load;
        logic [7:0]  pcl;
        logic [31:0] pc;
        logic [1:0]  exc;
    } stim_t;

    typedef struct packed {
        logic [1:0]  st;
        logic [1:0]  hc;
        logic [31:0] cc;
        logic        dp;
        logic        ple;
        logic [7:0]  plv;
    } snap_t;

    logic SYS_clk = 1'b0;
    logic SYS_reset;

    sys_exec_ctrl_if bus();

    sys_exec_ctrl dut (
        .SYS_clk   (SYS_clk),
        .SYS_reset (SYS_reset),
        .bus       (bus)
    );

    always #5 SYS_clk = ~SYS_clk;

    snap_t sbq[$];
    int    nCompared   = 0;
    int    nMismatched = 0;

    function automatic stim_t mkStim(input logic rst, input logic run, input logic step,
                                     input logic load, input logic [7:0] pcl,
                                     input logic [31:0] pc, input logic [1:0] exc);
        mkStim = {rst, run, step, load, pcl, pc, exc};
    endfunction

    function automatic snap_t mkSnap(input logic [1:0] st, input logic [1:0] hc,
                                     input logic [31:0] cc, input logic dp,
                                     input logic ple, input logic [7:0] plv);
        mkSnap = {st, hc, cc, dp, ple, plv};
    endfunction

    function automatic snap_t observe();
        observe = {bus.state, bus.halt_cause, bus.cycle_count,
                   bus.dp_enable, bus.pc_load_en, bus.pc_load_val};
    endfunction

    // Drive one cycle's inputs just after the falling edge, then let the
    // combinational enable settle before the caller samples.
    task automatic drive(input stim_t v);
        @(negedge SYS_clk);
        SYS_reset         = v.rst;
        bus.SYS_run       = v.run;
        bus.SYS_step      = v.step;
        bus.SYS_load      = v.load;
        bus.SYS_pc_load   = v.pcl;
        bus.pc_addr       = v.pc;
        bus.exception_sig = v.exc;
        #1;
    endtask

    task automatic doReset();
        drive(mkStim(1, 0, 0, 0, 8'h00, 32'h0, 2'b00));
        drive(mkStim(1, 0, 0, 0, 8'h00, 32'h0, 2'b00));
    endtask

    task automatic test_reset();
        stim_t s[$];
        snap_t e[$];
        snap_t obs;
        snap_t exp;
        bus.bp_en = 1'b0;
        doReset();
        s.push_back(mkStim(0, 0, 0, 1, 8'h3C, 32'h0, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'd0, 0, 0, 8'h00));
        s.push_back(mkStim(0, 0, 1, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'd0, 0, 1, 8'h3C));
        s.push_back(mkStim(0, 0, 1, 0, 8'h00, 32'h0, 2'b01)); e.push_back(mkSnap(2'd2, 2'd0, 32'd0, 1, 0, 8'h3C));
        s.push_back(mkStim(1, 0, 0, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd3, 2'd1, 32'd1, 0, 0, 8'h3C));
        s.push_back(mkStim(0, 0, 0, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'd0, 0, 0, 8'h00));
        foreach (s[i]) begin
            sbq.push_back(e[i]);
            drive(s[i]);
            obs = observe();
            exp = sbq.pop_front();
            nCompared++;
            if (obs !== exp) begin
                nMismatched++;
                $display("[TB] FAIL reset[%0d]: got st=%0d hc=%0d cc=%h dp=%0d ple=%0d plv=%h, want st=%0d hc=%0d cc=%h dp=%0d ple=%0d plv=%h",
                         i, obs.st, obs.hc, obs.cc, obs.dp, obs.ple, obs.plv, exp.st, exp.hc, exp.cc, exp.dp, exp.ple, exp.plv);
            end
        end
    endtask

    task automatic test_load();
        stim_t s[$];
        snap_t e[$];
        snap_t obs;
        snap_t exp;
        bus.bp_en = 1'b0;
        doReset();
        s.push_back(mkStim(0, 0, 1, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'd0, 0, 0, 8'h00));
        s.push_back(mkStim(0, 0, 1, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd2, 2'd0, 32'd0, 1, 0, 8'h00));
        s.push_back(mkStim(0, 0, 0, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'd1, 0, 0, 8'h00));
        s.push_back(mkStim(0, 1, 0, 1, 8'h2A, 32'h0, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'd1, 0, 0, 8'h00));
        s.push_back(mkStim(0, 0, 0, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'd0, 0, 1, 8'h2A));
        s.push_back(mkStim(0, 0, 0, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'd0, 0, 0, 8'h2A));
        foreach (s[i]) begin
            sbq.push_back(e[i]);
            drive(s[i]);
            obs = observe();
            exp = sbq.pop_front();
            nCompared++;
            if (obs !== exp) begin
                nMismatched++;
                $display("[TB] FAIL load[%0d]: got st=%0d hc=%0d cc=%h dp=%0d ple=%0d plv=%h, want st=%0d hc=%0d cc=%h dp=%0d ple=%0d plv=%h",
                         i, obs.st, obs.hc, obs.cc, obs.dp, obs.ple, obs.plv, exp.st, exp.hc, exp.cc, exp.dp, exp.ple, exp.plv);
            end
        end
    endtask

    task automatic test_step();
        stim_t s[$];
        snap_t e[$];
        snap_t obs;
        snap_t exp;
        bus.bp_en = 1'b0;
        doReset();
        for (int k = 0; k < 5; k++) begin
            s.push_back(mkStim(0, 0, 1, 0, 8'h00, 32'h0, 2'b00));
        end
        e.push_back(mkSnap(2'd0, 2'd0, 32'd0, 0, 0, 8'h00));
        e.push_back(mkSnap(2'd2, 2'd0, 32'd0, 1, 0, 8'h00));
        e.push_back(mkSnap(2'd0, 2'd0, 32'd1, 0, 0, 8'h00));
        e.push_back(mkSnap(2'd0, 2'd0, 32'd1, 0, 0, 8'h00));
        e.push_back(mkSnap(2'd0, 2'd0, 32'd1, 0, 0, 8'h00));
        s.push_back(mkStim(0, 0, 0, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'd1, 0, 0, 8'h00));
        s.push_back(mkStim(0, 1, 1, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'd1, 0, 0, 8'h00));
        s.push_back(mkStim(0, 1, 1, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd2, 2'd0, 32'd1, 1, 0, 8'h00));
        s.push_back(mkStim(0, 1, 1, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'd2, 0, 0, 8'h00));
        s.push_back(mkStim(0, 0, 0, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd1, 2'd0, 32'd2, 0, 0, 8'h00));
        s.push_back(mkStim(0, 0, 0, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'd2, 0, 0, 8'h00));
        foreach (s[i]) begin
            sbq.push_back(e[i]);
            drive(s[i]);
            obs = observe();
            exp = sbq.pop_front();
            nCompared++;
            if (obs !== exp) begin
                nMismatched++;
                $display("[TB] FAIL step[%0d]: got st=%0d hc=%0d cc=%h dp=%0d ple=%0d plv=%h, want st=%0d hc=%0d cc=%h dp=%0d ple=%0d plv=%h",
                         i, obs.st, obs.hc, obs.cc, obs.dp, obs.ple, obs.plv, exp.st, exp.hc, exp.cc, exp.dp, exp.ple, exp.plv);
            end
        end
    endtask

    task automatic test_breakpoint();
        stim_t s[$];
        snap_t e[$];
        snap_t obs;
        snap_t exp;
        bus.bp_en   = 1'b1;
        bus.bp_addr = 32'h10;
        doReset();
        s.push_back(mkStim(0, 1, 0, 0, 8'h00, 32'h00, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'd0, 0, 0, 8'h00));
        s.push_back(mkStim(0, 1, 0, 0, 8'h00, 32'h00, 2'b00)); e.push_back(mkSnap(2'd1, 2'd0, 32'd0, 1, 0, 8'h00));
        s.push_back(mkStim(0, 1, 0, 0, 8'h00, 32'h04, 2'b00)); e.push_back(mkSnap(2'd1, 2'd0, 32'd1, 1, 0, 8'h00));
        s.push_back(mkStim(0, 1, 0, 0, 8'h00, 32'h08, 2'b00)); e.push_back(mkSnap(2'd1, 2'd0, 32'd2, 1, 0, 8'h00));
        s.push_back(mkStim(0, 1, 0, 0, 8'h00, 32'h0C, 2'b00)); e.push_back(mkSnap(2'd1, 2'd0, 32'd3, 1, 0, 8'h00));
        s.push_back(mkStim(0, 1, 0, 0, 8'h00, 32'h10, 2'b00)); e.push_back(mkSnap(2'd1, 2'd0, 32'd4, 0, 0, 8'h00));
        s.push_back(mkStim(0, 1, 0, 0, 8'h00, 32'h10, 2'b00)); e.push_back(mkSnap(2'd3, 2'd2, 32'd4, 0, 0, 8'h00));
        s.push_back(mkStim(0, 0, 0, 0, 8'h00, 32'h10, 2'b00)); e.push_back(mkSnap(2'd3, 2'd2, 32'd4, 0, 0, 8'h00));
        s.push_back(mkStim(0, 1, 0, 0, 8'h00, 32'h10, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'd4, 0, 0, 8'h00));
        s.push_back(mkStim(0, 1, 0, 0, 8'h00, 32'h10, 2'b00)); e.push_back(mkSnap(2'd1, 2'd0, 32'd4, 1, 0, 8'h00));
        s.push_back(mkStim(0, 1, 0, 0, 8'h00, 32'h14, 2'b00)); e.push_back(mkSnap(2'd1, 2'd0, 32'd5, 1, 0, 8'h00));
        s.push_back(mkStim(0, 0, 0, 0, 8'h00, 32'h18, 2'b00)); e.push_back(mkSnap(2'd1, 2'd0, 32'd6, 0, 0, 8'h00));
        s.push_back(mkStim(0, 0, 0, 0, 8'h00, 32'h18, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'd6, 0, 0, 8'h00));
        foreach (s[i]) begin
            sbq.push_back(e[i]);
            drive(s[i]);
            obs = observe();
            exp = sbq.pop_front();
            nCompared++;
            if (obs !== exp) begin
                nMismatched++;
                $display("[TB] FAIL breakpoint[%0d]: got st=%0d hc=%0d cc=%h dp=%0d ple=%0d plv=%h, want st=%0d hc=%0d cc=%h dp=%0d ple=%0d plv=%h",
                         i, obs.st, obs.hc, obs.cc, obs.dp, obs.ple, obs.plv, exp.st, exp.hc, exp.cc, exp.dp, exp.ple, exp.plv);
            end
        end
        bus.bp_en = 1'b0;
    endtask

    task automatic test_exception();
        stim_t s[$];
        snap_t e[$];
        snap_t obs;
        snap_t exp;
        bus.bp_en = 1'b0;
        doReset();
        s.push_back(mkStim(0, 1, 0, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'd0, 0, 0, 8'h00));
        s.push_back(mkStim(0, 1, 0, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd1, 2'd0, 32'd0, 1, 0, 8'h00));
        s.push_back(mkStim(0, 1, 0, 0, 8'h00, 32'h4, 2'b00)); e.push_back(mkSnap(2'd1, 2'd0, 32'd1, 1, 0, 8'h00));
        s.push_back(mkStim(0, 1, 0, 0, 8'h00, 32'h8, 2'b01)); e.push_back(mkSnap(2'd1, 2'd0, 32'd2, 1, 0, 8'h00));
        s.push_back(mkStim(0, 1, 0, 0, 8'h00, 32'hC, 2'b00)); e.push_back(mkSnap(2'd3, 2'd1, 32'd3, 0, 0, 8'h00));
        s.push_back(mkStim(0, 0, 0, 0, 8'h00, 32'hC, 2'b00)); e.push_back(mkSnap(2'd3, 2'd1, 32'd3, 0, 0, 8'h00));
        s.push_back(mkStim(0, 0, 0, 0, 8'h00, 32'hC, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'd3, 0, 0, 8'h00));
        s.push_back(mkStim(0, 0, 1, 0, 8'h00, 32'hC, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'd3, 0, 0, 8'h00));
        s.push_back(mkStim(0, 0, 1, 0, 8'h00, 32'hC, 2'b10)); e.push_back(mkSnap(2'd2, 2'd0, 32'd3, 1, 0, 8'h00));
        s.push_back(mkStim(0, 0, 0, 1, 8'h55, 32'hC, 2'b00)); e.push_back(mkSnap(2'd3, 2'd1, 32'd4, 0, 0, 8'h00));
        s.push_back(mkStim(0, 0, 0, 0, 8'h00, 32'hC, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'd4, 0, 0, 8'h00));
        foreach (s[i]) begin
            sbq.push_back(e[i]);
            drive(s[i]);
            obs = observe();
            exp = sbq.pop_front();
            nCompared++;
            if (obs !== exp) begin
                nMismatched++;
                $display("[TB] FAIL exception[%0d]: got st=%0d hc=%0d cc=%h dp=%0d ple=%0d plv=%h, want st=%0d hc=%0d cc=%h dp=%0d ple=%0d plv=%h",
                         i, obs.st, obs.hc, obs.cc, obs.dp, obs.ple, obs.plv, exp.st, exp.hc, exp.cc, exp.dp, exp.ple, exp.plv);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        stim_t s[$];
        snap_t e[$];
        snap_t obs;
        snap_t exp;
        bus.bp_en = 1'b0;
        doReset();
        s.push_back(mkStim(0, 1, 0, 0, 8'h00, 32'h0, 2'b00));
        e.push_back(mkSnap(2'd0, 2'd0, 32'd0, 0, 0, 8'h00));
        for (int k = 1; k <= 7; k++) begin
            s.push_back(mkStim(0, 1, 0, (k == 3), 8'h77, 32'h0, 2'b00));
            e.push_back(mkSnap(2'd1, 2'd0, 32'(k - 1), 1, 0, 8'h00));
        end
        s.push_back(mkStim(1, 1, 0, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd1, 2'd0, 32'd7, 0, 0, 8'h00));
        s.push_back(mkStim(0, 1, 0, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'd0, 0, 0, 8'h00));
        s.push_back(mkStim(0, 0, 0, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd1, 2'd0, 32'd0, 0, 0, 8'h00));
        foreach (s[i]) begin
            sbq.push_back(e[i]);
            drive(s[i]);
            obs = observe();
            exp = sbq.pop_front();
            nCompared++;
            if (obs !== exp) begin
                nMismatched++;
                $display("[TB] FAIL reset_mid_run[%0d]: got st=%0d hc=%0d cc=%h dp=%0d ple=%0d plv=%h, want st=%0d hc=%0d cc=%h dp=%0d ple=%0d plv=%h",
                         i, obs.st, obs.hc, obs.cc, obs.dp, obs.ple, obs.plv, exp.st, exp.hc, exp.cc, exp.dp, exp.ple, exp.plv);
            end
        end
    endtask

    task automatic test_wrap();
        stim_t s[$];
        snap_t e[$];
        snap_t obs;
        snap_t exp;
        bus.bp_en = 1'b0;
        doReset();
        drive(mkStim(0, 0, 0, 0, 8'h00, 32'h0, 2'b00));
        force dut.r_cycleCount = 32'hFFFF_FFFF;
        #1;
        release dut.r_cycleCount;
        s.push_back(mkStim(0, 0, 1, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'hFFFF_FFFF, 0, 0, 8'h00));
        s.push_back(mkStim(0, 0, 0, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd2, 2'd0, 32'hFFFF_FFFF, 1, 0, 8'h00));
        s.push_back(mkStim(0, 0, 0, 0, 8'h00, 32'h0, 2'b00)); e.push_back(mkSnap(2'd0, 2'd0, 32'h0000_0000, 0, 0, 8'h00));
        foreach (s[i]) begin
            sbq.push_back(e[i]);
            drive(s[i]);
            obs = observe();
            exp = sbq.pop_front();
            nCompared++;
            if (obs !== exp) begin
                nMismatched++;
                $display("[TB] FAIL wrap[%0d]: got st=%0d hc=%0d cc=%h dp=%0d ple=%0d plv=%h, want st=%0d hc=%0d cc=%h dp=%0d ple=%0d plv=%h",
                         i, obs.st, obs.hc, obs.cc, obs.dp, obs.ple, obs.plv, exp.st, exp.hc, exp.cc, exp.dp, exp.ple, exp.plv);
            end
        end
    endtask

    initial begin
        SYS_reset         = 1'b1;
        bus.SYS_run       = 1'b0;
        bus.SYS_step      = 1'b0;
        bus.SYS_load      = 1'b0;
        bus.SYS_pc_load   = 8'h00;
        bus.bp_en         = 1'b0;
        bus.bp_addr       = 32'h0;
        bus.pc_addr       = 32'h0;
        bus.exception_sig = 2'b00;
        $display("[TB] starting sys_exec_ctrl scenarios");
        test_reset();
        test_load();
        test_step();
        test_breakpoint();
        test_exception();
        test_reset_mid_run();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/sys_exec_ctrl.md
SYS_EXEC_CTRL -- requirements
Module: sys_exec_ctrl

Interface
REQ-001 SHALL provide ports (name  direction  width  meaning):
- SYS_clk  input  1  single system clock; all state updates on rising edge.
- SYS_reset  input  1  synchronous, active-high reset.
- SYS_run  input  1  level; free-run request.
- SYS_step  input  1  level; single-step request, rising edge detected internally.
- SYS_load  input  1  PC load request, honoured in IDLE only.
- SYS_pc_load  input  8  PC load value.
- bp_en  input  1  breakpoint enable.
- bp_addr  input  32  breakpoint PC.
- pc_addr  input  32  current datapath PC.
- exception_sig  input  2  datapath exception flags; nonzero = fault.
- dp_enable  output  1  datapath advance enable, one instruction per asserted cycle.
- pc_load_en  output  1  one-cycle PC load strobe.
- pc_load_val  output  8  registered copy of SYS_pc_load.
- state  output  2  IDLE=00, RUN=01, STEP=10, HALT=11.
- halt_cause  output  2  00 none, 01 exception, 10 breakpoint.
- cycle_count  output  32  count of dp_enable cycles.

Function
REQ-002 SHALL hold step_q, a register of SYS_step; step_pulse = SYS_step & ~step_q.
REQ-003 State priority each cycle: SYS_reset > SYS_load > exception > breakpoint > run/step.
REQ-004 IDLE with SYS_load=1:
- Next cycle pc_load_en=1 for exactly one cycle; pc_load_val = SYS_pc_load sampled this cycle.
- cycle_count cleared; state stays IDLE.
REQ-005 IDLE, SYS_load=0: step_pulse -> STEP; else SYS_run=1 -> RUN; else stay. step_pulse wins if both are set.
REQ-006 SYS_load SHALL be ignored in RUN, STEP and HALT.
REQ-007 STEP: dp_enable=1 for exactly one cycle.
- Next state HALT with halt_cause=01 if exception_sig!=0 that cycle; else IDLE.
REQ-008 RUN: dp_enable=1 every cycle unless SYS_run=0 or a breakpoint hit.
REQ-009 Breakpoint hit = bp_en & (pc_addr==bp_addr) & ~entry.
- entry = 1 only on the first RUN cycle after entering from IDLE, so a resume from a breakpoint address proceeds.
REQ-010 RUN, breakpoint hit: dp_enable=0 that cycle; next state HALT, halt_cause=10.
REQ-011 RUN, dp_enable=1 and exception_sig!=0: next state HALT, halt_cause=01.
REQ-012 RUN, SYS_run=0: dp_enable=0 that cycle; next state IDLE.
REQ-013 HALT: dp_enable=0; stay until SYS_run=0, then IDLE with halt_cause cleared to 00 on that transition.
REQ-014 cycle_count SHALL increment by 1 in each cycle with dp_enable=1, wrapping 0xFFFFFFFF -> 0x00000000.
REQ-015 dp_enable SHALL be combinational from state, entry, bp compare and SYS_run. All other outputs SHALL be registered.
REQ-016 halt_cause SHALL change only on entry to HALT or exit from HALT.

Reset
REQ-017 On SYS_reset=1 at a clock edge, from any state including mid-RUN/STEP:
- state=IDLE, halt_cause=00, cycle_count=0, pc_load_en=0, pc_load_val=0, step_q=0, entry=0.
REQ-018 dp_enable SHALL be 0 in every cycle SYS_reset=1.

Verification
REQ-019 Load: IDLE, SYS_load=1, SYS_pc_load=0x2A for 1 cycle -> next cycle pc_load_en=1, pc_load_val=0x2A, cycle_count=0, state=IDLE.
REQ-020 Step: hold SYS_step=1 for 5 cycles -> dp_enable high exactly 1 cycle, cycle_count=1, state returns to 00.
REQ-021 Breakpoint: bp_en=1, bp_addr=0x10, run with pc_addr stepping 0x0,0x4,...:
- dp_enable low when pc_addr=0x10; state=11, halt_cause=10, cycle_count=4.
- Drop then raise SYS_run -> first RUN cycle proceeds past 0x10.
REQ-022 Exception: RUN, exception_sig=2'b01 on 3rd enabled cycle -> state=11, halt_cause=01, cycle_count=3; SYS_run=0 -> IDLE, halt_cause=00.
REQ-023 Reset mid-run: SYS_reset=1 during RUN with cycle_count=7 -> next cycle state=00, cycle_count=0, dp_enable=0.
REQ-024 Wrap: force cycle_count=0xFFFFFFFF, one STEP -> cycle_count=0x00000000.
